// File: rtl/timer_pkg.sv
// Shared definitions for the timer controller: default widths and FSM state encoding.
package timer_pkg;

  localparam int unsigned TIMER_WIDTH          = 32;
  localparam int unsigned TIMER_PRESCALE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/timer_controller_if.sv
// Configuration handshake, command and status bundle of the timer controller.
interface timer_controller_if #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned PRESCALE_WIDTH = 16
);

  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [WIDTH-1:0]          cfg_period;
  logic [PRESCALE_WIDTH-1:0] cfg_prescale;
  logic                      cfg_oneshot;
  logic                      start;
  logic                      pause;
  logic                      stop;
  logic                      tick;
  logic [WIDTH-1:0]          count_value;
  logic                      busy;
  logic                      done;
  logic                      err;

  modport master (
    output cfg_valid, cfg_period, cfg_prescale, cfg_oneshot, start, pause, stop,
    input  cfg_ready, tick, count_value, busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_prescale, cfg_oneshot, start, pause, stop,
    output cfg_ready, tick, count_value, busy, done, err
  );

endinterface

// File: rtl/prescale_counter.sv
// Enable-gated prescale counter: counts 0..terminal, strobes tc_c on the terminal cycle.
module prescale_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] terminal,
  output logic             tc_c
);

  logic [WIDTH-1:0] cnt_q;

  assign tc_c = en && (cnt_q == terminal);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc_c ? '0 : cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_controller.sv
// Timer sequencer: latches a configuration, runs a prescaled main count in periodic or
// one-shot mode, and pulses tick on every wrap.
module timer_controller
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH          = TIMER_WIDTH,
  parameter int unsigned PRESCALE_WIDTH = TIMER_PRESCALE_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  timer_controller_if.slave  bus
);

  state_e                    state_q;
  logic [WIDTH-1:0]          period_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic                      oneshot_q;
  logic [WIDTH-1:0]          count_q;
  logic                      tick_q;
  logic                      err_q;

  logic                      idle_like_c;
  logic                      accept_c;
  logic [WIDTH-1:0]          eff_period_c;
  logic                      launch_c;
  logic                      pre_en_c;
  logic                      pre_clr_c;
  logic                      pre_tc_c;

  // A config accepted on the same edge as start is the one the run uses.
  assign idle_like_c  = (state_q == IDLE) || (state_q == DONE);
  assign accept_c     = idle_like_c && bus.cfg_valid;
  assign eff_period_c = accept_c ? bus.cfg_period : period_q;
  assign launch_c     = idle_like_c && !bus.stop && !bus.pause && bus.start &&
                        (eff_period_c != '0);
  assign pre_en_c     = (state_q == RUN) && !bus.stop && !bus.pause;
  assign pre_clr_c    = bus.stop || launch_c;

  prescale_counter #(
    .WIDTH (PRESCALE_WIDTH)
  ) u_prescale (
    .clock    (clock),
    .reset    (reset),
    .en       (pre_en_c),
    .clr      (pre_clr_c),
    .terminal (prescale_q),
    .tc_c     (pre_tc_c)
  );

  // Sequencing FSM with registered main count and pulse outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      period_q   <= '0;
      prescale_q <= '0;
      oneshot_q  <= 1'b0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      err_q  <= 1'b0;

      if (accept_c) begin
        period_q   <= bus.cfg_period;
        prescale_q <= bus.cfg_prescale;
        oneshot_q  <= bus.cfg_oneshot;
      end

      if (bus.stop) begin
        state_q <= IDLE;
        count_q <= '0;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            if (!bus.pause && bus.start) begin
              if (launch_c) begin
                state_q <= RUN;
                count_q <= '0;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          RUN: begin
            if (bus.pause) begin
              state_q <= PAUSED;
            end else if (pre_tc_c) begin
              if (count_q == period_q - WIDTH'(1)) begin
                count_q <= '0;
                tick_q  <= 1'b1;
                if (oneshot_q) begin
                  state_q <= DONE;
                end
              end else begin
                count_q <= count_q + WIDTH'(1);
              end
            end
          end
          PAUSED: begin
            if (!bus.pause && bus.start) begin
              state_q <= RUN;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.cfg_ready   = idle_like_c;
  assign bus.busy        = (state_q == RUN) || (state_q == PAUSED);
  assign bus.done        = (state_q == DONE);
  assign bus.tick        = tick_q;
  assign bus.err         = err_q;
  assign bus.count_value = count_q;

endmodule

// File: doc/timer_controller.md
Name: timer_controller

Overview:
- Sequencing controller for a shared prescaled N-bit counter datapath. It accepts a configuration over a valid/ready handshake, then runs the counter in periodic or one-shot mode and emits a 1-cycle tick on each wrap.
- start/pause/stop commands drive the state machine. Used to generate divided enables/ticks for downstream logic without per-consumer hard-coded dividers.

Parameters:
- WIDTH, 32, width of period register and main count.
- PRESCALE_WIDTH, 16, width of prescale register and prescale count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted.
- cfg_period  in  WIDTH  main count period in prescaled steps.
- cfg_prescale  in  PRESCALE_WIDTH  prescale value P; divides by P+1.
- cfg_oneshot  in  1  1 = stop after first wrap, 0 = periodic.
- start  in  1  start from IDLE/DONE, resume from PAUSED.
- pause  in  1  freeze counting while in RUN.
- stop  in  1  abort to IDLE from any state.
- tick  out  1  1-cycle pulse per wrap.
- count_value  out  WIDTH  current main count.
- busy  out  1  high in RUN or PAUSED.
- done  out  1  high in DONE.
- err  out  1  1-cycle pulse when start is rejected.

Behaviour:
- Reset (reset=0, async): state=IDLE; period=0, prescale=0, oneshot=0; pre_cnt=0, count_value=0; tick=0, err=0, busy=0, done=0; cfg_ready=1.
- States: IDLE, RUN, PAUSED, DONE. busy and done are decoded from the state register, so they are registered.
- cfg_ready=1 only in IDLE or DONE.
  - cfg_valid&&cfg_ready at an edge latches period, prescale and oneshot.
  - cfg_valid in RUN/PAUSED is ignored and stays pending; the source must hold it until ready.
- Command priority per edge: stop > pause > start. cfg acceptance and start on the same edge are allowed; start then uses the newly latched values.
- IDLE/DONE + start:
  - Effective period != 0: go to RUN, pre_cnt=0, count_value=0. DONE -> RUN restarts from zero.
  - Effective period == 0: stay in the current state and pulse err for the cycle after that edge.
- RUN, each edge with no stop/pause:
  - If pre_cnt==prescale: pre_cnt<=0 and the count advances. Otherwise pre_cnt<=pre_cnt+1.
  - Advance with count_value==period-1: count_value<=0 and tick is high for the following cycle. Otherwise count_value+1.
  - Wrap with oneshot=1: go to DONE; count_value holds 0.
  - Result: tick period is period*(prescale+1) cycles. The first tick comes that many edges after the RUN-entry edge.
- RUN + pause: go to PAUSED; pre_cnt and count_value frozen; no advance on that edge.
- PAUSED + start: go to RUN, continuing from the frozen values. PAUSED + pause is a hold.
- stop in any state: go to IDLE; pre_cnt=0, count_value=0. No tick is produced on that edge even if a wrap would have occurred. Config registers are retained.
- Counts are unsigned, with no overflow beyond period-1. count_value never exceeds period-1 in RUN.
- tick and err are registered pulses, never asserted for 2 consecutive cycles unless period*(P+1)==1. With period=1 and P=0, tick is high continuously in RUN.
- Reset mid-operation: immediate return to reset values, including a tick in flight.

Decomposition:
- Shared package `timer_pkg`: state encoding localparams (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, DONE=2'd3) and the default widths.
- One sub-module `prescale_counter`:
  - Enable-gated PRESCALE_WIDTH counter with a programmable terminal value, sync clear, and a terminal-count strobe.
  - Async active-low reset.
  - The controller instantiates it and owns the main count and FSM.

Test Plan:
- cfg period=4, P=0, periodic; start -> tick on cycles 4, 8, 12 after RUN entry; count_value cycles 1,2,3,0.
- cfg period=3, P=1, periodic -> tick every 6 cycles; count_value changes every 2nd cycle.
- cfg period=5, P=0, oneshot; start -> exactly one tick at cycle 5; done=1, busy=0, cfg_ready=1; no further ticks over 20 cycles.
- period=8, P=0; pause at count_value=3 for 10 cycles, then start -> count stays 3 while paused; next tick 5 cycles after resume.
- period=4, P=0; stop asserted on the edge where count_value=3 -> no tick; IDLE, count_value=0. Then cfg_period=0 + start -> err pulses once and state stays IDLE.
- RUN with period=6: cfg_valid held with period=2 -> cfg_ready=0, config ignored. Drive reset=0 mid-run -> all outputs zero immediately, cfg_ready=1.
